axi_mem_responder: RTL and testbench

// - AXI4 subordinate memory model. It is the responder end of the memory AXI master port of the

---
 rtl/axi_mem_responder.sv | 244 ++++++++++++++++++++++++
 tb/tb_axi_mem_responder.sv | 265 ++++++++++++++++++++++++++
 2 files changed

// File: rtl/axi_mem_responder.sv
// AXI4 subordinate word-RAM model with independent write (AW/W/B) and read (AR/R) engines, one burst each.
// Latency: AR handshake to first rvalid is 2 cycles, 1 read beat per 2 cycles; W beats accepted back-to-back.
// Backpressure: bvalid and all R fields hold until bready/rready; optional WRAP bursts via AXI_MEM_RESPONDER_WRAP_EN.
module axi_mem_responder #(
    parameter int AXI_DATA_W = 64,
    parameter int AXI_ADDR_W = 32,
    parameter int AXI_ID_W   = 6,
    parameter int AXI_STRB_W = 8,
    parameter int MEM_DEPTH  = 1024
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic [AXI_ID_W-1:0]   awid,
    input  logic [AXI_ADDR_W-1:0] awaddr,
    input  logic [7:0]            awlen,
    input  logic [2:0]            awsize,
    input  logic [1:0]            awburst,
    input  logic                  awvalid,
    output logic                  awready,
    input  logic [AXI_DATA_W-1:0] wdata,
    input  logic [AXI_STRB_W-1:0] wstrb,
    input  logic                  wlast,
    input  logic                  wvalid,
    output logic                  wready,
    output logic [AXI_ID_W-1:0]   bid,
    output logic [2:0]            bresp,
    output logic                  bvalid,
    input  logic                  bready,
    input  logic [AXI_ID_W-1:0]   arid,
    input  logic [AXI_ADDR_W-1:0] araddr,
    input  logic [7:0]            arlen,
    input  logic [2:0]            arsize,
    input  logic [1:0]            arburst,
    input  logic                  arvalid,
    output logic                  arready,
    output logic [AXI_ID_W-1:0]   rid,
    output logic [AXI_DATA_W-1:0] rdata,
    output logic [2:0]            rresp,
    output logic                  rlast,
    output logic                  rvalid,
    input  logic                  rready
);

    localparam int LOG2_STRB = $clog2(AXI_STRB_W);
    localparam int IDX_W     = $clog2(MEM_DEPTH);
    localparam logic [AXI_ADDR_W-1:0] DEPTH_A = AXI_ADDR_W'(MEM_DEPTH);
    localparam logic [2:0] RESP_OKAY   = 3'b000;
    localparam logic [2:0] RESP_SLVERR = 3'b010;
`ifdef AXI_MEM_RESPONDER_WRAP_EN
    localparam bit WRAP_OK = 1'b1;
`else
    localparam bit WRAP_OK = 1'b0;
`endif

    typedef enum logic [1:0] {W_IDLE, W_DATA, W_RESP} w_state_t;
    typedef enum logic [1:0] {R_IDLE, R_FETCH, R_DATA} r_state_t;

    // Whole-burst error: only full-width beats, no reserved burst, WRAP only when built in with len 1/3/7/15.
    function automatic logic f_illegal(input logic [2:0] size, input logic [1:0] burst,
                                       input logic [7:0] len);
        logic bad;
        bad = (size != 3'(LOG2_STRB));
        case (burst)
            2'b11:   bad = 1'b1;
            2'b10:   if (!WRAP_OK || !(len == 8'd1 || len == 8'd3 || len == 8'd7 || len == 8'd15))
                         bad = 1'b1;
            default: ;
        endcase
        return bad;
    endfunction

    // Next word index: FIXED holds, INCR adds one with no modulo, WRAP stays inside a (len+1)-word aligned window.
    function automatic logic [AXI_ADDR_W-1:0] f_step(input logic [AXI_ADDR_W-1:0] addr,
                                                     input logic [1:0] burst, input logic [7:0] len);
        logic [AXI_ADDR_W-1:0] mask;
        logic [AXI_ADDR_W-1:0] inc;
        mask = {{(AXI_ADDR_W-8){1'b0}}, len};
        inc  = addr + AXI_ADDR_W'(1);
        case (burst)
            2'b00:   return addr;
            2'b10:   return (addr & ~mask) | (inc & mask);
            default: return inc;
        endcase
    endfunction

    logic [AXI_DATA_W-1:0] r_mem [MEM_DEPTH];

    w_state_t              r_w_state, w_w_next;
    logic [AXI_ID_W-1:0]   r_w_id;
    logic [AXI_ADDR_W-1:0] r_w_addr;
    logic [7:0]            r_w_len, r_w_beat;
    logic [1:0]            r_w_burst;
    logic                  r_w_err;

    r_state_t              r_r_state, w_r_next;
    logic [AXI_ID_W-1:0]   r_r_id;
    logic [AXI_ADDR_W-1:0] r_r_addr;
    logic [7:0]            r_r_len, r_r_beat;
    logic [1:0]            r_r_burst;
    logic                  r_r_err;
    logic [AXI_DATA_W-1:0] r_rdata;
    logic [2:0]            r_rresp;
    logic                  r_rlast;

    logic                  w_w_inrange, w_w_hs, w_w_last_beat, w_r_inrange;
    logic [IDX_W-1:0]      w_w_idx, w_r_idx;

    assign w_w_inrange   = (r_w_addr < DEPTH_A);
    assign w_w_idx       = r_w_addr[IDX_W-1:0];
    assign w_w_hs        = (r_w_state == W_DATA) && wvalid;
    assign w_w_last_beat = (r_w_beat == r_w_len);
    assign w_r_inrange   = (r_r_addr < DEPTH_A);
    assign w_r_idx       = r_r_addr[IDX_W-1:0];

    // Write engine state register and burst context; errors are sticky for the rest of the burst.
    always_ff @(posedge clk) begin
        if (!rst) begin
            r_w_state <= W_IDLE;
            r_w_id    <= '0;
            r_w_addr  <= '0;
            r_w_len   <= '0;
            r_w_beat  <= '0;
            r_w_burst <= '0;
            r_w_err   <= 1'b0;
        end else begin
            r_w_state <= w_w_next;
            if (r_w_state == W_IDLE && awvalid) begin
                r_w_id    <= awid;
                r_w_addr  <= awaddr >> LOG2_STRB;
                r_w_len   <= awlen;
                r_w_burst <= awburst;
                r_w_beat  <= '0;
                r_w_err   <= f_illegal(awsize, awburst, awlen);
            end else if (w_w_hs) begin
                if (!w_w_inrange || (wlast != w_w_last_beat))
                    r_w_err <= 1'b1;
                r_w_beat <= r_w_beat + 8'd1;
                r_w_addr <= f_step(r_w_addr, r_w_burst, r_w_len);
            end
        end
    end

    // Write engine next state and AW/W/B handshake outputs.
    always_comb begin
        w_w_next = r_w_state;
        awready  = 1'b0;
        wready   = 1'b0;
        bvalid   = 1'b0;
        bid      = '0;
        bresp    = RESP_OKAY;
        case (r_w_state)
            W_IDLE: begin
                awready = 1'b1;
                if (awvalid) w_w_next = W_DATA;
            end
            W_DATA: begin
                wready = 1'b1;
                if (wvalid && wlast) w_w_next = W_RESP;
            end
            W_RESP: begin
                bvalid = 1'b1;
                bid    = r_w_id;
                bresp  = r_w_err ? RESP_SLVERR : RESP_OKAY;
                if (bready) w_w_next = W_IDLE;
            end
            default: w_w_next = W_IDLE;
        endcase
    end

    // RAM byte-lane writes; contents survive reset, nothing lands once the burst has errored.
    always_ff @(posedge clk) begin
        if (rst && w_w_hs && !r_w_err && w_w_inrange) begin
            for (int b = 0; b < AXI_STRB_W; b++) begin
                if (wstrb[b]) r_mem[w_w_idx][b*8 +: 8] <= wdata[b*8 +: 8];
            end
        end
    end

    // Read engine state register, burst context and the registered R beat (RAM read is read-first).
    always_ff @(posedge clk) begin
        if (!rst) begin
            r_r_state <= R_IDLE;
            r_r_id    <= '0;
            r_r_addr  <= '0;
            r_r_len   <= '0;
            r_r_beat  <= '0;
            r_r_burst <= '0;
            r_r_err   <= 1'b0;
            r_rdata   <= '0;
            r_rresp   <= RESP_OKAY;
            r_rlast   <= 1'b0;
        end else begin
            r_r_state <= w_r_next;
            case (r_r_state)
                R_IDLE: if (arvalid) begin
                    r_r_id    <= arid;
                    r_r_addr  <= araddr >> LOG2_STRB;
                    r_r_len   <= arlen;
                    r_r_burst <= arburst;
                    r_r_beat  <= '0;
                    r_r_err   <= f_illegal(arsize, arburst, arlen);
                end
                R_FETCH: begin
                    r_rdata <= (r_r_err || !w_r_inrange) ? '0 : r_mem[w_r_idx];
                    r_rresp <= (r_r_err || !w_r_inrange) ? RESP_SLVERR : RESP_OKAY;
                    r_rlast <= (r_r_beat == r_r_len);
                end
                R_DATA: if (rready) begin
                    r_r_beat <= r_r_beat + 8'd1;
                    r_r_addr <= f_step(r_r_addr, r_r_burst, r_r_len);
                end
                default: ;
            endcase
        end
    end

    // Read engine next state and AR/R handshake outputs.
    always_comb begin
        w_r_next = r_r_state;
        arready  = 1'b0;
        rvalid   = 1'b0;
        rid      = '0;
        rdata    = '0;
        rresp    = RESP_OKAY;
        rlast    = 1'b0;
        case (r_r_state)
            R_IDLE: begin
                arready = 1'b1;
                if (arvalid) w_r_next = R_FETCH;
            end
            R_FETCH: w_r_next = R_DATA;
            R_DATA: begin
                rvalid = 1'b1;
                rid    = r_r_id;
                rdata  = r_rdata;
                rresp  = r_rresp;
                rlast  = r_rlast;
                if (rready) w_r_next = r_rlast ? R_IDLE : R_FETCH;
            end
            default: w_r_next = R_IDLE;
        endcase
    end

endmodule

// File: tb/tb_axi_mem_responder.sv
// Directed bench for axi_mem_responder: table of write/read bursts plus overlap, stall and reset sequences.
// Latency: checks the 2-cycle AR-to-rvalid latency on every unstalled table read.
// Backpressure: exercises rready toggling and a delayed bready while both engines run.
module tb_axi_mem_responder;

    logic        clk = 1'b0;
    logic        rst;
    logic [5:0]  awid, arid, bid, rid;
    logic [31:0] awaddr, araddr;
    logic [7:0]  awlen, arlen, wstrb;
    logic [2:0]  awsize, arsize, bresp, rresp;
    logic [1:0]  awburst, arburst;
    logic        awvalid, awready, wlast, wvalid, wready, bvalid, bready;
    logic        arvalid, arready, rlast, rvalid, rready;
    logic [63:0] wdata, rdata;

    always #5 clk = ~clk;

    axi_mem_responder dut (
        .clk(clk), .rst(rst),
        .awid(awid), .awaddr(awaddr), .awlen(awlen), .awsize(awsize), .awburst(awburst),
        .awvalid(awvalid), .awready(awready),
        .wdata(wdata), .wstrb(wstrb), .wlast(wlast), .wvalid(wvalid), .wready(wready),
        .bid(bid), .bresp(bresp), .bvalid(bvalid), .bready(bready),
        .arid(arid), .araddr(araddr), .arlen(arlen), .arsize(arsize), .arburst(arburst),
        .arvalid(arvalid), .arready(arready),
        .rid(rid), .rdata(rdata), .rresp(rresp), .rlast(rlast), .rvalid(rvalid), .rready(rready)
    );

    int chk = 0;
    int fail = 0;

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        chk++;
        if (act !== exp) begin
            fail++;
            $display("FAIL %s: got 0x%h, expected 0x%h", name, act, exp);
        end
    endtask

    task automatic timeout(input string name);
        chk++;
        fail++;
        $display("FAIL %s: timed out waiting on the DUT", name);
    endtask

    logic [2:0]  b_resp;
    logic [5:0]  b_id;
    int          b_held;

    // Drives one write burst; lastb is the beat carrying wlast, bwait delays bready.
    task automatic do_write(input logic [5:0] id, input logic [31:0] addr, input logic [7:0] len,
                            input logic [2:0] size, input logic [1:0] burst, input logic [7:0] strb,
                            input int lastb, input logic [7:0][63:0] dat, input int bwait);
        int n;
        awid = id; awaddr = addr; awlen = len; awsize = size; awburst = burst; awvalid = 1'b1;
        n = 0;
        while (!awready && n < 50) begin @(negedge clk); n++; end
        if (!awready) timeout("aw_handshake");
        @(negedge clk);
        awvalid = 1'b0;
        for (int i = 0; i <= lastb; i++) begin
            wdata = dat[i]; wstrb = strb; wlast = (i == lastb); wvalid = 1'b1;
            n = 0;
            while (!wready && n < 50) begin @(negedge clk); n++; end
            if (!wready) timeout("w_handshake");
            @(negedge clk);
        end
        wvalid = 1'b0; wlast = 1'b0;
        n = 0;
        while (!bvalid && n < 50) begin @(negedge clk); n++; end
        if (!bvalid) timeout("b_wait");
        b_resp = bresp; b_id = bid; b_held = 0;
        for (int i = 0; i < bwait; i++) begin
            @(negedge clk);
            if (bvalid && bresp == b_resp && bid == b_id) b_held++;
        end
        bready = 1'b1;
        @(negedge clk);
        bready = 1'b0;
    endtask

    logic [63:0] rb_dat  [16];
    logic [2:0]  rb_resp [16];
    logic        rb_last [16];
    logic [5:0]  rb_id   [16];
    int          r_lat;
    int          r_stall_err;

    // Drives one read burst and records every accepted beat; toggle makes rready go 1,0,1,0...
    task automatic do_read(input logic [5:0] id, input logic [31:0] addr, input logic [7:0] len,
                           input logic [2:0] size, input logic [1:0] burst, input bit toggle);
        int n, nb, cyc, guard;
        bit stalled, seen;
        logic [63:0] hd; logic [2:0] hr; logic hl; logic [5:0] hi;
        arid = id; araddr = addr; arlen = len; arsize = size; arburst = burst; arvalid = 1'b1;
        n = 0;
        while (!arready && n < 50) begin @(negedge clk); n++; end
        if (!arready) timeout("ar_handshake");
        @(negedge clk);
        arvalid = 1'b0;
        nb = 0; cyc = 0; guard = 0; stalled = 0; seen = 0; r_lat = 1; r_stall_err = 0;
        hd = '0; hr = '0; hl = 1'b0; hi = '0;
        while (nb <= int'(len) && guard < 200) begin
            rready = toggle ? (cyc % 2 == 0) : 1'b1;
            if (rvalid) begin
                seen = 1;
                if (stalled && (rdata !== hd || rresp !== hr || rlast !== hl || rid !== hi))
                    r_stall_err++;
                if (rready) begin
                    rb_dat[nb] = rdata; rb_resp[nb] = rresp; rb_last[nb] = rlast; rb_id[nb] = rid;
                    nb++;
                    stalled = 0;
                end else begin
                    stalled = 1;
                    hd = rdata; hr = rresp; hl = rlast; hi = rid;
                end
            end else if (!seen) begin
                r_lat++;
            end
            @(negedge clk);
            cyc++; guard++;
        end
        rready = 1'b0;
        if (nb <= int'(len)) timeout("r_beats");
    endtask

    typedef struct {
        bit               wr;
        logic [5:0]       id;
        logic [31:0]      addr;
        logic [7:0]       len;
        logic [2:0]       size;
        logic [1:0]       burst;
        logic [7:0]       strb;
        int               lastb;
        logic [7:0][63:0] d;
        logic [2:0]       resp;
    } vec_t;

    function automatic vec_t mkv(input bit wr, input logic [5:0] id, input logic [31:0] addr,
                                 input logic [7:0] len, input logic [2:0] size, input logic [1:0] burst,
                                 input logic [7:0] strb, input int lastb,
                                 input logic [63:0] d0, input logic [63:0] d1,
                                 input logic [63:0] d2, input logic [63:0] d3, input logic [2:0] resp);
        vec_t v;
        v.wr = wr; v.id = id; v.addr = addr; v.len = len; v.size = size; v.burst = burst;
        v.strb = strb; v.lastb = lastb; v.resp = resp;
        v.d = '0;
        v.d[0] = d0; v.d[1] = d1; v.d[2] = d2; v.d[3] = d3;
        return v;
    endfunction

    localparam int NV = 17;
    vec_t vt [NV];
    logic [7:0][63:0] pat_a, pat_b;

    initial begin
        #2000000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        // write: wr id addr len size burst strb lastb d0..d3 bresp / read: expected rdata and rresp
        vt[0]  = mkv(1, 6'd5,  32'h40,   8'd3, 3'd3, 2'b01, 8'hFF, 3, 64'h11, 64'h22, 64'h33, 64'h44, 3'b000);
        vt[1]  = mkv(0, 6'd9,  32'h40,   8'd3, 3'd3, 2'b01, 8'hFF, 3, 64'h11, 64'h22, 64'h33, 64'h44, 3'b000);
        vt[2]  = mkv(1, 6'd1,  32'h80,   8'd0, 3'd3, 2'b01, 8'hFF, 0, 64'hFFFF_FFFF_FFFF_FFFF, 0, 0, 0, 3'b000);
        vt[3]  = mkv(1, 6'd2,  32'h80,   8'd0, 3'd3, 2'b01, 8'h0F, 0, 64'h0, 0, 0, 0, 3'b000);
        vt[4]  = mkv(0, 6'd3,  32'h80,   8'd0, 3'd3, 2'b01, 8'hFF, 0, 64'hFFFF_FFFF_0000_0000, 0, 0, 0, 3'b000);
        vt[5]  = mkv(0, 6'd4,  32'h2000, 8'd0, 3'd3, 2'b01, 8'hFF, 0, 64'h0, 0, 0, 0, 3'b010);
        vt[6]  = mkv(1, 6'd6,  32'hC0,   8'd3, 3'd3, 2'b01, 8'hFF, 1, 64'hAA, 64'hBB, 0, 0, 3'b010);
        vt[7]  = mkv(1, 6'd7,  32'h40,   8'd0, 3'd2, 2'b01, 8'hFF, 0, 64'hDEAD, 0, 0, 0, 3'b010);
        vt[8]  = mkv(0, 6'd8,  32'h40,   8'd0, 3'd3, 2'b01, 8'hFF, 0, 64'h11, 0, 0, 0, 3'b000);
        vt[9]  = mkv(1, 6'd10, 32'h100,  8'd2, 3'd3, 2'b00, 8'hFF, 2, 64'h1, 64'h2, 64'h3, 0, 3'b000);
        vt[10] = mkv(0, 6'd11, 32'h100,  8'd0, 3'd3, 2'b01, 8'hFF, 0, 64'h3, 0, 0, 0, 3'b000);
        vt[11] = mkv(0, 6'd12, 32'h40,   8'd0, 3'd3, 2'b11, 8'hFF, 0, 64'h0, 0, 0, 0, 3'b010);
        vt[12] = mkv(1, 6'd13, 32'h2000, 8'd0, 3'd3, 2'b01, 8'hFF, 0, 64'h77, 0, 0, 0, 3'b010);
        vt[13] = mkv(1, 6'd14, 32'h0,    8'd3, 3'd3, 2'b01, 8'hFF, 3, 64'hA0, 64'hA1, 64'hA2, 64'hA3, 3'b000);
`ifdef AXI_MEM_RESPONDER_WRAP_EN
        vt[14] = mkv(0, 6'd15, 32'h18,   8'd3, 3'd3, 2'b10, 8'hFF, 3, 64'hA3, 64'hA0, 64'hA1, 64'hA2, 3'b000);
`else
        vt[14] = mkv(0, 6'd15, 32'h18,   8'd3, 3'd3, 2'b10, 8'hFF, 3, 64'h0, 64'h0, 64'h0, 64'h0, 3'b010);
`endif
        vt[15] = mkv(0, 6'd16, 32'h08,   8'd1, 3'd3, 2'b01, 8'hFF, 1, 64'hA1, 64'hA2, 0, 0, 3'b000);
        vt[16] = mkv(1, 6'd17, 32'hC0,   8'd1, 3'd3, 2'b01, 8'hFF, 2, 64'h5, 64'h6, 64'h7, 0, 3'b010);

        for (int i = 0; i < 8; i++) begin
            pat_a[i] = 64'h0101_0101_0101_0101 * (i + 1);
            pat_b[i] = 64'hF0E0_0000_0000_0000 + 64'(i * 3 + 1);
        end

        rst = 1'b0;
        awid = '0; awaddr = '0; awlen = '0; awsize = '0; awburst = '0; awvalid = 1'b0;
        wdata = '0; wstrb = '0; wlast = 1'b0; wvalid = 1'b0; bready = 1'b0;
        arid = '0; araddr = '0; arlen = '0; arsize = '0; arburst = '0; arvalid = 1'b0; rready = 1'b0;
        repeat (3) @(negedge clk);
        check("rst_awready", awready, 1);
        check("rst_arready", arready, 1);
        check("rst_bvalid", bvalid, 0);
        check("rst_rvalid", rvalid, 0);
        check("rst_wready", wready, 0);
        rst = 1'b1;
        @(negedge clk);

        for (int k = 0; k < NV; k++) begin
            if (vt[k].wr) begin
                do_write(vt[k].id, vt[k].addr, vt[k].len, vt[k].size, vt[k].burst, vt[k].strb,
                         vt[k].lastb, vt[k].d, 0);
                check($sformatf("v%0d_bresp", k), b_resp, vt[k].resp);
                check($sformatf("v%0d_bid", k), b_id, vt[k].id);
            end else begin
                do_read(vt[k].id, vt[k].addr, vt[k].len, vt[k].size, vt[k].burst, 1'b0);
                check($sformatf("v%0d_latency", k), r_lat, 2);
                for (int i = 0; i <= int'(vt[k].len); i++) begin
                    check($sformatf("v%0d_b%0d_rdata", k, i), rb_dat[i], vt[k].d[i]);
                    check($sformatf("v%0d_b%0d_rresp", k, i), rb_resp[i], vt[k].resp);
                    check($sformatf("v%0d_b%0d_rlast", k, i), rb_last[i], i == int'(vt[k].len));
                    check($sformatf("v%0d_b%0d_rid", k, i), rb_id[i], vt[k].id);
                end
            end
        end

        // Overlapping len=7 write (bready held off 5 cycles) and stalled len=7 read.
        do_write(6'd19, 32'h200, 8'd7, 3'd3, 2'b01, 8'hFF, 7, pat_a, 0);
        check("ovl_pre_bresp", b_resp, 3'b000);
        fork
            do_write(6'd20, 32'h300, 8'd7, 3'd3, 2'b01, 8'hFF, 7, pat_b, 5);
            do_read(6'd21, 32'h200, 8'd7, 3'd3, 2'b01, 1'b1);
        join
        for (int i = 0; i < 8; i++) begin
            check($sformatf("ovl_rd_b%0d_rdata", i), rb_dat[i], pat_a[i]);
            check($sformatf("ovl_rd_b%0d_rlast", i), rb_last[i], i == 7);
            check($sformatf("ovl_rd_b%0d_rresp", i), rb_resp[i], 3'b000);
        end
        check("ovl_rd_stall_stable", r_stall_err, 0);
        check("ovl_bvalid_held", b_held, 5);
        check("ovl_bresp", b_resp, 3'b000);
        check("ovl_bid", b_id, 6'd20);
        check("ovl_bvalid_after", bvalid, 0);
        do_read(6'd22, 32'h300, 8'd7, 3'd3, 2'b01, 1'b0);
        for (int i = 0; i < 8; i++)
            check($sformatf("ovl_wr_b%0d_rdata", i), rb_dat[i], pat_b[i]);

        // Mid-run reset keeps RAM contents.
        rst = 1'b0;
        repeat (3) @(negedge clk);
        check("rst2_awready", awready, 1);
        check("rst2_arready", arready, 1);
        check("rst2_bvalid", bvalid, 0);
        check("rst2_rvalid", rvalid, 0);
        check("rst2_wready", wready, 0);
        rst = 1'b1;
        @(negedge clk);
        do_read(6'd23, 32'h40, 8'd3, 3'd3, 2'b01, 1'b0);
        for (int i = 0; i < 4; i++) begin
            check($sformatf("rst2_keep_b%0d", i), rb_dat[i], 64'h11 * (i + 1));
            check($sformatf("rst2_rlast_b%0d", i), rb_last[i], i == 3);
        end

        $display("End of test - %0d assertions evaluated, %0d failures", chk, fail);
        $finish;
    end

endmodule
